// File: rtl/chime_sequencer.sv
// chime_sequencer: turns each new hourly alarm rise into a radio time signal,
// PIPS short 250 Hz pips followed by one long 500 Hz pip, on a 1 kHz clock.
module chime_sequencer #(
  parameter int PIPS    = 3,
  parameter int PIP_MS  = 100,
  parameter int GAP_MS  = 100,
  parameter int LONG_MS = 300
) (
  input  logic _1kHzIN,
  input  logic CR,
  input  logic ALARM_Radio,
  input  logic Chime_En,
  output logic Speaker,
  output logic Busy,
  output logic Done
);

  localparam int MAX_A  = (PIP_MS > GAP_MS) ? PIP_MS : GAP_MS;
  localparam int MAX_MS = (MAX_A > LONG_MS) ? MAX_A : LONG_MS;
  localparam int DW     = $clog2(MAX_MS + 1);

  localparam logic [DW-1:0] PIP_LAST  = DW'(PIP_MS - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_MS - 1);
  localparam logic [DW-1:0] LONG_LAST = DW'(LONG_MS - 1);
  localparam logic [2:0]    PIPS_C    = 3'(PIPS);

  typedef enum logic [1:0] {IDLE, PIP_ON, PIP_OFF, LONG_ON} state_t;

  // trigger path
  logic       sync1_q, a_s_q, a_d_q, rise_q, armed_q;
  logic [1:0] fill_q;

  // sequencer
  state_t        state_q;
  logic [DW-1:0] dur_q;
  logic [2:0]    pip_q;
  logic [1:0]    ph_q;
  logic          spk_q, busy_q, done_q;

  logic [DW-1:0] dur_d;
  logic [2:0]    pip_d;
  logic [1:0]    ph_d;

  assign dur_d = dur_q + DW'(1);
  assign pip_d = pip_q + 3'd1;
  assign ph_d  = ph_q + 2'd1;

  assign Speaker = spk_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

  // Synchronize the alarm level, detect its rise, and arm only once a genuine
  // low level has been seen after reset (fill_q marks real samples in a_s_q),
  // so a level already high at reset release never chimes.
  always_ff @(posedge _1kHzIN) begin
    if (CR) begin
      sync1_q <= 1'b0;
      a_s_q   <= 1'b0;
      a_d_q   <= 1'b0;
      rise_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= ALARM_Radio;
      a_s_q   <= sync1_q;
      a_d_q   <= a_s_q;
      rise_q  <= a_s_q & ~a_d_q;
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1] && !a_s_q) armed_q <= 1'b1;
    end
  end

  // Pip sequencer FSM; outputs are registered from the next state so Busy
  // and Speaker line up cycle-exactly with the state register.
  always_ff @(posedge _1kHzIN) begin
    if (CR) begin
      state_q <= IDLE;
      dur_q   <= '0;
      pip_q   <= '0;
      ph_q    <= '0;
      spk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && !Chime_En) begin
        state_q <= IDLE;
        dur_q   <= '0;
        ph_q    <= '0;
        spk_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (armed_q && Chime_En && rise_q) begin
              state_q <= PIP_ON;
              pip_q   <= '0;
              dur_q   <= '0;
              ph_q    <= '0;
              spk_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          PIP_ON: begin
            if (dur_q == PIP_LAST) begin
              state_q <= PIP_OFF;
              dur_q   <= '0;
              spk_q   <= 1'b0;
            end else begin
              dur_q <= dur_d;
              ph_q  <= ph_d;
              spk_q <= ~ph_d[1];
            end
          end
          PIP_OFF: begin
            if (dur_q == GAP_LAST) begin
              state_q <= (pip_d == PIPS_C) ? LONG_ON : PIP_ON;
              pip_q   <= pip_d;
              dur_q   <= '0;
              ph_q    <= '0;
              spk_q   <= 1'b1;
            end else begin
              dur_q <= dur_d;
            end
          end
          LONG_ON: begin
            if (dur_q == LONG_LAST) begin
              state_q <= IDLE;
              dur_q   <= '0;
              spk_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              dur_q <= dur_d;
              ph_q  <= ph_d;
              spk_q <= ~ph_d[0];
            end
          end
          default: begin
            state_q <= IDLE;
            spk_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chime_sequencer.sv
// tb_chime_sequencer: drives one default-parameter and one minimal-parameter
// sequencer from shared stimulus; a reference model predicts each cycle's
// {Speaker,Busy,Done} into per-instance queues, a monitor pops and compares.
module tb_chime_sequencer;

  logic clk = 1'b0;
  logic CR, ALARM, EN;
  logic spk_d, busy_d, done_d;
  logic spk_s, busy_s, done_s;

  always #5 clk = ~clk;

  chime_sequencer dut_d (
    ._1kHzIN(clk), .CR(CR), .ALARM_Radio(ALARM), .Chime_En(EN),
    .Speaker(spk_d), .Busy(busy_d), .Done(done_d)
  );

  chime_sequencer #(.PIPS(1), .PIP_MS(1), .GAP_MS(1), .LONG_MS(2)) dut_s (
    ._1kHzIN(clk), .CR(CR), .ALARM_Radio(ALARM), .Chime_En(EN),
    .Speaker(spk_s), .Busy(busy_s), .Done(done_s)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [2:0] q0[$];
  logic [2:0] q1[$];

  // reference model parameters per instance
  int np_a[2] = '{3, 1};
  int pm_a[2] = '{100, 1};
  int gm_a[2] = '{100, 1};
  int lm_a[2] = '{300, 2};

  // Expected tone bit at busy index k, from the pip timetable.
  function automatic logic spk_at(int k, int np, int pm, int gm, int lm);
    int per;
    per = pm + gm;
    if (k < np * per) begin
      if ((k % per) < pm) return (((k % per) / 2) % 2) == 0;
      return 1'b0;
    end
    return ((k - np * per) % 2) == 0;
  endfunction

  // model state
  int         post = 0;
  logic [4:0] sh   = '0;
  bit         act[2];
  int         idx[2];

  always @(posedge clk) begin
    logic [2:0] e;
    logic       rise;
    int         total;
    cyc++;
    if (CR) begin
      post = 0;
      sh   = '0;
      for (int d = 0; d < 2; d++) begin
        act[d] = 1'b0;
        idx[d] = 0;
        if (d == 0) q0.push_back(3'b000); else q1.push_back(3'b000);
      end
    end else begin
      post++;
      sh   = {sh[3:0], ALARM};
      // a sampled low-then-high pair, both after reset, starts a chime 3 edges later
      rise = (post >= 5) && sh[3] && !sh[4];
      for (int d = 0; d < 2; d++) begin
        total = np_a[d] * (pm_a[d] + gm_a[d]) + lm_a[d];
        e = 3'b000;
        if (act[d]) begin
          if (!EN) begin
            act[d] = 1'b0;
          end else begin
            idx[d]++;
            if (idx[d] == total) begin
              act[d] = 1'b0;
              e = 3'b001;
            end else begin
              e = {spk_at(idx[d], np_a[d], pm_a[d], gm_a[d], lm_a[d]), 2'b10};
            end
          end
        end else if (rise && EN) begin
          act[d] = 1'b1;
          idx[d] = 0;
          e = {spk_at(0, np_a[d], pm_a[d], gm_a[d], lm_a[d]), 2'b10};
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  end

  // monitor: compare every predicted cycle on the falling edge
  always @(negedge clk) begin
    logic [2:0] ex, ac;
    if (q0.size() > 0) begin
      ex = q0.pop_front();
      ac = {spk_d, busy_d, done_d};
      tests++;
      if (ac !== ex) begin
        fails++;
        $display("FAIL dflt cyc=%0d spk/busy/done got %b want %b", cyc, ac, ex);
      end
    end
    if (q1.size() > 0) begin
      ex = q1.pop_front();
      ac = {spk_s, busy_s, done_s};
      tests++;
      if (ac !== ex) begin
        fails++;
        $display("FAIL small cyc=%0d spk/busy/done got %b want %b", cyc, ac, ex);
      end
    end
  end

  task automatic hold(input logic a, input logic e, input logic r, input int n);
    ALARM = a;
    EN    = e;
    CR    = r;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    logic a, e, r;
    // reset then a clean 1000-cycle alarm
    hold(0, 1, 1, 2);
    hold(0, 1, 0, 5);
    hold(1, 1, 0, 1000);
    hold(0, 1, 0, 20);
    // second pulse mid-sequence is ignored
    hold(1, 1, 0, 100);
    hold(0, 1, 0, 50);
    hold(1, 1, 0, 5);
    hold(0, 1, 0, 900);
    // enable dropped mid-sequence, then a fresh full sequence
    hold(1, 1, 0, 453);
    hold(1, 0, 0, 5);
    hold(0, 1, 0, 10);
    hold(1, 1, 0, 5);
    hold(0, 1, 0, 950);
    // reset during the long pip with alarm held high, then re-arm
    hold(1, 1, 0, 623);
    hold(1, 1, 1, 3);
    hold(1, 1, 0, 100);
    hold(0, 1, 0, 3);
    hold(1, 1, 0, 950);
    hold(0, 1, 0, 10);
    // rise while disabled is dropped, not queued
    hold(0, 0, 0, 5);
    hold(1, 0, 0, 20);
    hold(1, 1, 0, 980);
    hold(0, 1, 0, 10);
    // randomized traffic
    repeat (120) begin
      a = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 9) != 0);
      r = 1'($urandom_range(0, 49) == 0);
      n = r ? $urandom_range(1, 3) : $urandom_range(1, 60);
      if (!r && $urandom_range(0, 7) == 0) n = $urandom_range(300, 700);
      hold(a, e, r, n);
    end
    hold(0, 1, 0, 5);
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
